// File: rtl/div_ctrl_pkg.sv
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared state encodings, bus widths and handshake constants
//               for the divider sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DivCtrlIdle    = 2'd0,
        DivCtrlRun     = 2'd1,
        DivCtrlRelease = 2'd2
    } div_ctrl_state_e;

    localparam logic c_DIV_START        = 1'b1;
    localparam logic c_DIV_STOP         = 1'b0;
    localparam logic c_DIV_RESULT_READY = 1'b1;

    localparam int c_REG_W  = 32;
    localparam int c_DREG_W = 64;
    localparam int c_KEY_W  = 65;

    typedef logic [c_REG_W-1:0]  reg_bus_t;
    typedef logic [c_DREG_W-1:0] dreg_bus_t;
    typedef logic [c_KEY_W-1:0]  div_key_t;

    function automatic div_key_t div_key(input logic sgn, input reg_bus_t a, input reg_bus_t b);
        return {sgn, a, b};
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_result_cache.sv
// ============================================================================
// Module      : div_result_cache
// Description : One-entry {sign,op1,op2} -> {remainder,quotient} cache with a
//               combinational hit compare and a single write port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module div_result_cache
    import div_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [c_KEY_W-1:0]  wr_key,
    input  logic [c_DREG_W-1:0] wr_val,
    input  logic [c_KEY_W-1:0]  rd_key,
    output logic                hit,
    output logic [c_DREG_W-1:0] rd_val
);

    logic                r_valid;
    logic [c_KEY_W-1:0]  r_key;
    logic [c_DREG_W-1:0] r_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_key   <= '0;
            r_val   <= '0;
        end else if (wr_en) begin
            r_valid <= 1'b1;
            r_key   <= wr_key;
            r_val   <= wr_val;
        end
    end

    assign hit    = r_valid && (r_key == rd_key);
    assign rd_val = r_val;

endmodule

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// Module      : div_ctrl
// Description : EX-stage sequencer for the multi-cycle divider: start/annul
//               handshake, pipeline stall, HI/LO write, result cache, watchdog.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam int              c_CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    div_ctrl_state_e     r_state;
    logic [c_CNT_W-1:0]  r_cnt;

    logic                w_hit;
    logic [c_DREG_W-1:0] w_cache_val;
    logic                w_cache_we;
    logic                w_launch;
    logic                w_leave;
    logic [c_KEY_W-1:0]  w_req_key;
    logic [c_KEY_W-1:0]  w_run_key;

    assign w_req_key = div_key(div_signed_i, op1_i, op2_i);
    assign w_run_key = div_key(div_signed_o, div_op1_o, div_op2_o);

    // Handshake outputs are combinational so hits and completions cost no extra cycle.
    always_comb begin
        stall_o     = 1'b0;
        hilo_we_o   = 1'b0;
        hi_o        = '0;
        lo_o        = '0;
        timeout_o   = 1'b0;
        div_annul_o = 1'b0;
        w_cache_we  = 1'b0;
        w_launch    = 1'b0;
        w_leave     = 1'b0;
        if (rst) begin
            case (r_state)
                DivCtrlIdle: begin
                    if (div_req_i && !flush_i) begin
                        if (w_hit) begin
                            hilo_we_o    = 1'b1;
                            {hi_o, lo_o} = w_cache_val;
                        end else begin
                            stall_o  = 1'b1;
                            w_launch = 1'b1;
                        end
                    end
                end
                DivCtrlRun: begin
                    if (flush_i) begin
                        div_annul_o = 1'b1;
                        w_leave     = 1'b1;
                    end else if (div_ready_i == c_DIV_RESULT_READY) begin
                        hilo_we_o    = 1'b1;
                        {hi_o, lo_o} = div_result_i;
                        w_cache_we   = 1'b1;
                        w_leave      = 1'b1;
                    end else if (r_cnt == c_CNT_LAST) begin
                        timeout_o   = 1'b1;
                        div_annul_o = 1'b1;
                        w_leave     = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                DivCtrlRelease: begin
                    stall_o = div_req_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= DivCtrlIdle;
            r_cnt        <= '0;
            div_start_o  <= c_DIV_STOP;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
        end else begin
            case (r_state)
                DivCtrlIdle: begin
                    if (w_launch) begin
                        div_start_o  <= c_DIV_START;
                        div_signed_o <= div_signed_i;
                        div_op1_o    <= op1_i;
                        div_op2_o    <= op2_i;
                        r_cnt        <= '0;
                        r_state      <= DivCtrlRun;
                    end
                end
                DivCtrlRun: begin
                    if (w_leave) begin
                        div_start_o  <= c_DIV_STOP;
                        div_signed_o <= 1'b0;
                        div_op1_o    <= '0;
                        div_op2_o    <= '0;
                        r_state      <= DivCtrlRelease;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DivCtrlRelease: begin
                    // The divider holds ready until it sees start low; restart only once it drops.
                    if (div_ready_i != c_DIV_RESULT_READY) begin
                        r_state <= DivCtrlIdle;
                    end
                end
                default: r_state <= DivCtrlIdle;
            endcase
        end
    end

    generate
        if (CACHE_EN) begin : g_cache
            div_result_cache u_cache (
                .clk    (clk),
                .rst    (rst),
                .wr_en  (w_cache_we),
                .wr_key (w_run_key),
                .wr_val (div_result_i),
                .rd_key (w_req_key),
                .hit    (w_hit),
                .rd_val (w_cache_val)
            );
        end else begin : g_no_cache
            assign w_hit       = 1'b0;
            assign w_cache_val = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Sequencer between the EX stage and the multi-cycle divider. It accepts div/divu requests from EX and drives the divider start/annul handshake. It stalls the pipeline until the quotient and remainder are available, then issues a one-cycle HI/LO write. A one-entry result cache returns repeated divisions without restarting the divider. A watchdog aborts a divider that never reports ready.

Parameters:
CACHE_EN, 1, 1 = enable one-entry result cache; 0 = every request starts the divider
TIMEOUT, 64, max cycles in RUN before abort (must exceed divider latency of 34)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
div_req_i  in  1  EX holds a div/divu this cycle
div_signed_i  in  1  1 = div (signed), 0 = divu
op1_i  in  32  dividend
op2_i  in  32  divisor
flush_i  in  1  pipeline flush; kills the in-flight request
stall_o  out  1  stall request to pipeline control
hilo_we_o  out  1  HI/LO write enable, one cycle per completed request
hi_o  out  32  remainder
lo_o  out  32  quotient
timeout_o  out  1  one-cycle pulse on watchdog abort
div_start_o  out  1  to divider start
div_annul_o  out  1  to divider annul
div_signed_o  out  1  to divider sign select
div_op1_o  out  32  to divider dividend
div_op2_o  out  32  to divider divisor
div_result_i  in  64  from divider, {remainder, quotient}
div_ready_i  in  1  from divider, result valid; held until start drops

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, cache invalid, watchdog counter 0. Reset mid-RUN takes effect immediately with no write.
- States: IDLE, RUN, RELEASE.
- IDLE, no request or flush_i=1: all outputs 0.
- IDLE, req with cache hit (CACHE_EN, valid, key {signed,op1,op2} matches):
  - Same cycle: stall_o=0, hilo_we_o=1, hi/lo taken from cache.
  - Divider is not touched; state stays IDLE.
- IDLE, req with cache miss:
  - Same cycle: stall_o=1 (combinational).
  - Register the operands and sign; div_start_o<=1; counter<=0; go to RUN.
- RUN:
  - div_start_o=1; div_op*/div_signed_o held stable; counter increments.
  - While div_ready_i=0: stall_o=1.
  - div_ready_i=1 and flush_i=0 (same cycle):
    - stall_o=0, hilo_we_o=1, hi_o=div_result_i[63:32], lo_o=div_result_i[31:0].
    - Cache <= {key, result}, valid=1.
    - div_start_o<=0; go to RELEASE.
  - flush_i=1 (priority over ready): div_annul_o=1 for that cycle; no write, no cache update; div_start_o<=0; go to RELEASE.
  - counter reaches TIMEOUT-1 without ready: timeout_o=1, div_annul_o=1, no write, stall_o=0; go to RELEASE.
- RELEASE:
  - div_start_o=0.
  - Wait for div_ready_i=0, then go to IDLE.
  - Any request here gets stall_o=1, including cache hits; it is accepted in IDLE.
  - flush_i is ignored.
- Divide-by-zero: no special path. The divider returns 0, so hi=lo=0 and that result is cached.
- hilo_we_o is never asserted for more than one cycle per request.
- div_start_o never rises while div_ready_i=1.

Decomposition:
- Shared defines file: state encodings DivCtrlIdle/Run/Release, and the existing DivStart/DivStop, DivResultReady, RegBus and DoubleRegBus macros.
- One natural sub-module: div_result_cache.
  - Holds the valid bit, 65-bit key and 64-bit value.
  - Provides combinational hit compare and a write port.
  - Instantiated only when CACHE_EN=1.

Test Plan:
- divu 100/7, cold cache -> stall_o high until ready; single hilo_we_o with lo=14, hi=2; div_start_o falls the next cycle.
- Repeat divu 100/7 immediately after IDLE -> hit: hilo_we_o in the request cycle, stall_o=0, div_start_o stays 0.
- div 0xFFFFFFF9/2 (signed -7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then divu of same operands -> miss (sign in key), lo=0x7FFFFFFC, hi=1.
- flush_i at RUN cycle 10 -> div_annul_o one cycle, no hilo_we_o, cache unchanged, IDLE within 2 cycles.
- divu 5/0 -> hi=lo=0 written once; divider model that never readies -> timeout_o after 64 cycles with annul and no write.
- Back-to-back misses 9/3 then 8/3 -> second stalls through RELEASE; writes lo=3,hi=0 then lo=2,hi=2. rst pulsed low mid-RUN -> outputs 0 immediately, cache invalid.
